// File: rtl/mul_pkg.sv
// mul_pkg: state type, legal step widths and counter sizing shared by the sequential multiplier
package mul_pkg;
  typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_FIN} mul_state_t;
  localparam int BPC_1 = 1;
  localparam int BPC_2 = 2;
  localparam int BPC_4 = 4;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mul_step.sv
// mul_step: adds one BPC-bit slice of the multiplier times the shifted multiplicand to the running product
module mul_step #(
  parameter int PW  = 64,
  parameter int BPC = 1
) (
  input  logic [PW-1:0]  product,
  input  logic [PW-1:0]  mcand,
  input  logic [BPC-1:0] bits,
  output logic [PW-1:0]  next_product
);
  always_comb begin
    next_product = product;
    for (int i = 0; i < BPC; i++) next_product = next_product + (bits[i] ? mcand << i : '0);
  end
endmodule

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiply/accumulate, BPC multiplier bits per cycle.
// Define MUL_EARLY_EXIT_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 issigned,
  input  logic                 accumulate,
  input  logic [2*WIDTH-1:0]   acc,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_w(N);
  localparam int PW = 2 * WIDTH;
  if ((WIDTH % BPC) != 0 || !(BPC == BPC_1 || BPC == BPC_2 || BPC == BPC_4)) begin : g_bad_cfg
    $error("seq_mul: BPC must be 1, 2 or 4 and divide WIDTH");
  end
  mul_state_t state, state_nxt;
  logic [PW-1:0]    mcand, product, acc_r, step_sum, p_fin;
  logic [WIDTH-1:0] mplier, abs_a, abs_b;
  logic [CW-1:0]    count;
  logic             neg, acc_en, skip, last;
  // Magnitudes stay unsigned in WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow
  assign abs_a = (issigned && a[WIDTH-1]) ? ~a + WIDTH'(1) : a;
  assign abs_b = (issigned && b[WIDTH-1]) ? ~b + WIDTH'(1) : b;
  assign last  = count == CW'(N - 1);
  assign p_fin = neg ? ~product + PW'(1) : product;
  assign busy  = state != MS_IDLE;
`ifdef MUL_EARLY_EXIT_EN
  assign skip = mplier == '0;
`else
  assign skip = 1'b0;
`endif
  mul_step #(.PW(PW), .BPC(BPC)) u_step (
    .product      (product),
    .mcand        (mcand),
    .bits         (mplier[BPC-1:0]),
    .next_product (step_sum)
  );
  always_comb begin
    state_nxt = (state == MS_IDLE) ? (start ? MS_RUN : MS_IDLE) :
                (state == MS_RUN)  ? ((skip || last) ? MS_FIN : MS_RUN) : MS_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MS_IDLE;
    else          state <= state_nxt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      acc_r   <= '0;
      count   <= '0;
      neg     <= 1'b0;
      acc_en  <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (state == MS_IDLE && start) begin
        mcand   <= PW'(abs_a);
        mplier  <= abs_b;
        neg     <= issigned & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_en  <= accumulate;
        acc_r   <= acc;
        product <= '0;
        count   <= '0;
      end
      if (state == MS_RUN && !skip) begin
        product <= step_sum;
        mcand   <= mcand << BPC;
        mplier  <= mplier >> BPC;
        count   <= count + CW'(1);
      end
      if (state == MS_FIN) begin
        result <= p_fin + (acc_en ? acc_r : '0);
        done   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: randomized and directed scoreboard bench for seq_mul against an arithmetic reference model
module tb_seq_mul;
  parameter int BPC = 1;
  localparam int W = 32;
  localparam int N = W / BPC;
  typedef struct {
    logic [2*W-1:0] res;
    int             at;
  } exp_t;
  logic           clk = 1'b0, reset_n = 1'b0, start = 1'b0, issigned = 1'b0, accumulate = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic [2*W-1:0] acc = '0;
  logic           busy, done;
  logic [2*W-1:0] result;
  int             errors = 0, checks = 0, cyc = 0;
  exp_t           exp_q[$];
  exp_t           mon_e;
  seq_mul #(.WIDTH(W), .BPC(BPC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .issigned   (issigned),
    .accumulate (accumulate),
    .acc        (acc),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask
  // Reference: full-width product of the sign/zero-extended operands, plus the addend, mod 2^(2W)
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic s,
                                 input logic ae, input logic [2*W-1:0] macc, input int e0);
    exp_t           r;
    logic [2*W-1:0] ea, eb;
    logic [W-1:0]   mag;
    int             l, run;
    ea = s ? {{W{ma[W-1]}}, ma} : {{W{1'b0}}, ma};
    eb = s ? {{W{mb[W-1]}}, mb} : {{W{1'b0}}, mb};
    r.res = ea * eb + (ae ? macc : '0);
    run = N;
    mag = (s && mb[W-1]) ? -mb : mb;
    l = 0;
    for (int i = 0; i < W; i++) if (mag[i]) l = i + 1;
`ifdef MUL_EARLY_EXIT_EN
    run = (l + BPC - 1) / BPC + 1;
    if (run > N) run = N;
`endif
    r.at = e0 + run + 1;
    return r;
  endfunction
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s,
                       input logic ae, input logic [2*W-1:0] iacc);
    exp_q.push_back(model(ia, ib, s, ae, iacc, cyc + 1));
    a = ia;
    b = ib;
    issigned = s;
    accumulate = ae;
    acc = iacc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    acc = {$urandom, $urandom};
    issigned = 1'($urandom);
    accumulate = 1'($urandom);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("done_timeout", {63'b0, done}, 64'd1);
  endtask
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      chk("busy_done_excl", {63'b0, busy & done}, '0);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", {63'b0, done}, '0);
        else begin
          mon_e = exp_q.pop_front();
          chk("result", result, mon_e.res);
          chk("latency", 64'(cyc), 64'(mon_e.at));
        end
      end
    end
  end
  initial begin
    #1;
    chk("rst_busy", {63'b0, busy}, '0);
    chk("rst_done", {63'b0, done}, '0);
    chk("rst_result", result, '0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    wait_done();
    chk("t1_const", result, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {63'b0, done}, '0);
    chk("result_held", result, 64'hFFFF_FFFE_0000_0001);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, '0);
    wait_done();
    chk("t2_neg", result, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, '0);
    wait_done();
    chk("t2_minneg", result, 64'h4000_0000_0000_0000);
    issue(32'd7, 32'd6, 1'b0, 1'b1, 64'h100);
    wait_done();
    chk("t3_mla", result, 64'h12A);
    issue(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 64'd1);
    wait_done();
    chk("t3_smla", result, '0);
    issue(32'd1, 32'd0, 1'b0, 1'b1, 64'h55);
    wait_done();
    issue(32'h1234_5678, 32'd1, 1'b0, 1'b0, '0);
    wait_done();
    issue(32'd1234, 32'd5678, 1'b0, 1'b0, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    a = 32'd99;
    b = 32'd77;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("t4_ignored_start", result, 64'd7006652);
    issue(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    wait_done();
    issue(32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 1'b0, '0);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, '0);
    chk("arst_done", {63'b0, done}, '0);
    chk("arst_result", result, '0);
    exp_q.delete();
    #4;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd3, 32'd4, 1'b0, 1'b0, '0);
    wait_done();
    chk("post_rst", result, 64'd12);
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = W'($urandom_range(0, 15));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom), 1'($urandom), {$urandom, $urandom});
      wait_done();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
